// File: rtl/coproc_pkg.sv
// Shared opcodes, widths and issuer state encoding
// for the image coprocessor command path.
package coproc_pkg;

  localparam int ADDR_W = 17;
  localparam int PIX_W  = 8;

  localparam logic [2:0] NOP         = 3'd0;
  localparam logic [2:0] LOAD        = 3'd1;
  localparam logic [2:0] STORE       = 3'd2;
  localparam logic [2:0] ZOOM_IN_VP  = 3'd3;
  localparam logic [2:0] ZOOM_IN_RP  = 3'd4;
  localparam logic [2:0] ZOOM_OUT_MP = 3'd5;
  localparam logic [2:0] ZOOM_OUT_VD = 3'd6;
  localparam logic [2:0] RESET_INST  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_SETTLE,
    ST_RESPOND
  } issuer_state_t;

  // NOP and RESET never pull FLAG_DONE low
  function automatic logic has_busy_phase(
    input logic [2:0] op
  );
    return !(op == NOP || op == RESET_INST);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one coprocessor
// status bit, with a selectable reset value.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // shift the raw bit through the flop chain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr <= {STAGES{RST_VAL}};
    end else begin
      sr[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/coproc_cmd_issuer.sv
// Host-side command issuer: strobes the coprocessor
// bus and tracks the FLAG_DONE busy/done handshake.
module coproc_cmd_issuer
  import coproc_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int BUSY_TIMEOUT  = 64,
  parameter int DONE_TIMEOUT  = 1048575,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_opcode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [PIX_W-1:0]  req_data,
  output logic              rsp_valid,
  output logic [PIX_W-1:0]  rsp_data,
  output logic              rsp_error,
  output logic              rsp_zoom_max,
  output logic              rsp_zoom_min,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [2:0]        INSTRUCTION,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [PIX_W-1:0]  DATA_IN,
  output logic              ENABLE,
  input  logic              FLAG_DONE,
  input  logic              FLAG_ERROR,
  input  logic              FLAG_ZOOM_MAX,
  input  logic              FLAG_ZOOM_MIN,
  input  logic [PIX_W-1:0]  DATA_OUT
);

  localparam int M0 =
    (SETUP_CYCLES > STROBE_CYCLES) ?
    SETUP_CYCLES : STROBE_CYCLES;
  localparam int M1 =
    (M0 > SETTLE_CYCLES) ? M0 : SETTLE_CYCLES;
  localparam int M2 =
    (M1 > BUSY_TIMEOUT) ? M1 : BUSY_TIMEOUT;
  localparam int M3 =
    (M2 > DONE_TIMEOUT) ? M2 : DONE_TIMEOUT;
  localparam int CNT_W = $clog2(M3 + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST =
    CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST =
    CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST =
    CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST =
    CNT_W'(DONE_TIMEOUT - 1);

  issuer_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             go_rsp;
  logic             go_to;
  logic             done_s;
  logic             err_s;
  logic             zmax_s;
  logic             zmin_s;

  // done resets high so the bus reads idle
  sync_bit #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync_done (
    .clock(clock),
    .reset(reset),
    .d    (FLAG_DONE),
    .q    (done_s)
  );

  sync_bit #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync_err (
    .clock(clock),
    .reset(reset),
    .d    (FLAG_ERROR),
    .q    (err_s)
  );

  sync_bit #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync_zmax (
    .clock(clock),
    .reset(reset),
    .d    (FLAG_ZOOM_MAX),
    .q    (zmax_s)
  );

  sync_bit #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync_zmin (
    .clock(clock),
    .reset(reset),
    .d    (FLAG_ZOOM_MIN),
    .q    (zmin_s)
  );

  assign req_ready = (state == ST_IDLE) && done_s;
  assign busy      = (state != ST_IDLE);

  // exit conditions of the waiting states
  always_comb begin
    cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    go_rsp  = 1'b0;
    go_to   = 1'b0;
    unique case (state)
      ST_WAIT_BUSY: begin
        if (done_s && cnt == BUSY_LAST) begin
          go_rsp = 1'b1;
          go_to  = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (done_s) begin
          go_rsp = 1'b1;
        end else if (cnt == DONE_LAST) begin
          go_rsp = 1'b1;
          go_to  = 1'b1;
        end
      end
      ST_SETTLE: go_rsp = (cnt == SETTLE_LAST);
      default: ;
    endcase
  end

  // command sequencer with registered bus outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ENABLE       <= 1'b1;
      INSTRUCTION  <= '0;
      MEM_ADDR     <= '0;
      DATA_IN      <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_error    <= 1'b0;
      rsp_zoom_max <= 1'b0;
      rsp_zoom_min <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (go_rsp) begin
        state        <= ST_RESPOND;
        cnt          <= '0;
        rsp_valid    <= 1'b1;
        rsp_data     <= (INSTRUCTION == LOAD) ?
                        DATA_OUT : '0;
        rsp_error    <= err_s;
        rsp_zoom_max <= zmax_s;
        rsp_zoom_min <= zmin_s;
        rsp_timeout  <= go_to;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (req_valid && req_ready) begin
              INSTRUCTION <= req_opcode;
              MEM_ADDR    <= req_addr;
              DATA_IN     <= req_data;
              cnt         <= '0;
              state       <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (cnt == SETUP_LAST) begin
              cnt    <= '0;
              ENABLE <= 1'b0;
              state  <= ST_STROBE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_STROBE: begin
            if (cnt == STROBE_LAST) begin
              cnt    <= '0;
              ENABLE <= 1'b1;
              state  <= has_busy_phase(INSTRUCTION) ?
                        ST_WAIT_BUSY : ST_SETTLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_WAIT_BUSY: begin
            if (!done_s) begin
              cnt   <= '0;
              state <= ST_WAIT_DONE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_WAIT_DONE: cnt <= cnt_inc;
          ST_SETTLE:    cnt <= cnt_inc;
          ST_RESPOND:   state <= ST_IDLE;
          default:      state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coproc_cmd_issuer.sv
// Randomized bench for coproc_cmd_issuer against a
// timeline model of the issuer and coprocessor.
`timescale 1ns/1ps
module tb_coproc_cmd_issuer;
  import coproc_pkg::*;

  localparam int S  = 2;
  localparam int P  = 4;
  localparam int BT = 64;
  localparam int ST = 8;
  localparam int NH = 16384;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_opcode;
  logic [16:0] req_addr;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic        rsp_zoom_max;
  logic        rsp_zoom_min;
  logic        rsp_timeout;
  logic        busy;
  logic [2:0]  INSTRUCTION;
  logic [16:0] MEM_ADDR;
  logic [7:0]  DATA_IN;
  logic        ENABLE;
  logic        FLAG_DONE;
  logic        FLAG_ERROR;
  logic        FLAG_ZOOM_MAX;
  logic        FLAG_ZOOM_MIN;
  logic [7:0]  DATA_OUT;

  always #5 clock = ~clock;

  coproc_cmd_issuer #(
    .SETUP_CYCLES (S),
    .STROBE_CYCLES(P),
    .SYNC_STAGES  (2),
    .BUSY_TIMEOUT (BT),
    .DONE_TIMEOUT (1048575),
    .SETTLE_CYCLES(ST)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_error    (rsp_error),
    .rsp_zoom_max (rsp_zoom_max),
    .rsp_zoom_min (rsp_zoom_min),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy),
    .INSTRUCTION  (INSTRUCTION),
    .MEM_ADDR     (MEM_ADDR),
    .DATA_IN      (DATA_IN),
    .ENABLE       (ENABLE),
    .FLAG_DONE    (FLAG_DONE),
    .FLAG_ERROR   (FLAG_ERROR),
    .FLAG_ZOOM_MAX(FLAG_ZOOM_MAX),
    .FLAG_ZOOM_MIN(FLAG_ZOOM_MIN),
    .DATA_OUT     (DATA_OUT)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cyc = 7;

  bit         fd_h [NH];
  bit         er_h [NH];
  bit         zx_h [NH];
  bit         zn_h [NH];
  logic [7:0] do_h [NH];

  int a_cyc   = -1000;
  int rsp_cyc = -1000;
  int win_lo  = 0;
  int win_n   = 0;
  int upd_cyc = -1000;

  logic [2:0]  c_op = '0;
  logic [2:0]  p_op = '0;
  logic [16:0] c_ad = '0;
  logic [16:0] p_ad = '0;
  logic [7:0]  c_dt = '0;
  logic [7:0]  p_dt = '0;
  bit          c_to = 1'b0;

  bit         pe_e, pe_zx, pe_zn;
  logic [7:0] pe_do;

  logic [7:0] e_data = '0;
  bit e_err = 1'b0;
  bit e_zx  = 1'b0;
  bit e_zn  = 1'b0;
  bit e_to  = 1'b0;

  int dut_rsp_cyc = -1;
  int en_low = 0;

  task automatic chk(input string nm,
                     input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               nm, cyc, got, exp);
    end
  endtask

  function automatic bit m_busy(input int c);
    return c > a_cyc && c <= rsp_cyc;
  endfunction

  function automatic bit m_ready(input int c);
    return !m_busy(c) && fd_h[c-2];
  endfunction

  // compare every output against the model each cycle
  always @(negedge clock) begin
    if (chk_en) begin
      if (cyc == rsp_cyc) begin
        e_data = (c_op == LOAD) ? do_h[cyc-1] : 8'h00;
        e_err  = er_h[cyc-3];
        e_zx   = zx_h[cyc-3];
        e_zn   = zn_h[cyc-3];
        e_to   = c_to;
      end
      if (!ENABLE) en_low++;
      if (rsp_valid) dut_rsp_cyc = cyc;
      chk("enable", int'(ENABLE),
          int'(!(cyc >= a_cyc + S + 1 &&
                 cyc <= a_cyc + S + P)));
      chk("busy", int'(busy), int'(m_busy(cyc)));
      chk("req_ready", int'(req_ready),
          int'(m_ready(cyc)));
      chk("rsp_valid", int'(rsp_valid),
          int'(cyc == rsp_cyc));
      chk("instruction", int'(INSTRUCTION),
          int'((cyc > a_cyc) ? c_op : p_op));
      chk("mem_addr", int'(MEM_ADDR),
          int'((cyc > a_cyc) ? c_ad : p_ad));
      chk("data_in", int'(DATA_IN),
          int'((cyc > a_cyc) ? c_dt : p_dt));
      chk("rsp_data", int'(rsp_data), int'(e_data));
      chk("rsp_error", int'(rsp_error), int'(e_err));
      chk("rsp_zoom_max", int'(rsp_zoom_max),
          int'(e_zx));
      chk("rsp_zoom_min", int'(rsp_zoom_min),
          int'(e_zn));
      chk("rsp_timeout", int'(rsp_timeout),
          int'(e_to));
    end
  end

  // one host cycle: coprocessor model plus request
  task automatic step(input bit v,
                      input logic [2:0] op,
                      input logic [16:0] ad,
                      input logic [7:0] dt,
                      input int dly,
                      input int n,
                      input logic [7:0] dout,
                      input bit e,
                      input bit zx,
                      input bit zn,
                      output bit acc);
    int f;
    int r;
    bit bop;
    @(posedge clock);
    #1;
    cyc++;
    FLAG_DONE = !(win_n > 0 && cyc >= win_lo &&
                  cyc < win_lo + win_n);
    if (cyc == upd_cyc) begin
      FLAG_ERROR    = pe_e;
      FLAG_ZOOM_MAX = pe_zx;
      FLAG_ZOOM_MIN = pe_zn;
      DATA_OUT      = pe_do;
    end
    fd_h[cyc] = FLAG_DONE;
    er_h[cyc] = FLAG_ERROR;
    zx_h[cyc] = FLAG_ZOOM_MAX;
    zn_h[cyc] = FLAG_ZOOM_MIN;
    do_h[cyc] = DATA_OUT;
    req_valid  = v;
    req_opcode = op;
    req_addr   = ad;
    req_data   = dt;
    acc = v && m_ready(cyc);
    if (acc) begin
      p_op = c_op; p_ad = c_ad; p_dt = c_dt;
      c_op = op;   c_ad = ad;   c_dt = dt;
      a_cyc = cyc;
      f = cyc + S + 1;
      r = cyc + S + P + 1;
      bop = !(op == NOP || op == RESET_INST);
      win_lo = f + dly;
      win_n  = bop ? n : 0;
      upd_cyc = (win_n > 0) ? win_lo + win_n : cyc + 1;
      pe_e = e; pe_zx = zx; pe_zn = zn; pe_do = dout;
      if (!bop) begin
        rsp_cyc = r + ST;
        c_to = 1'b0;
      end else if (win_n > 0 &&
                   win_lo + win_n + 1 >= r) begin
        rsp_cyc = win_lo + win_n + 3;
        c_to = 1'b0;
      end else begin
        rsp_cyc = r + BT;
        c_to = 1'b1;
      end
      en_low = 0;
    end
  endtask

  task automatic send(input logic [2:0] op,
                      input logic [16:0] ad,
                      input logic [7:0] dt,
                      input int dly,
                      input int n,
                      input logic [7:0] dout,
                      input bit e,
                      input bit zx,
                      input bit zn);
    bit acc = 1'b0;
    bit junk;
    int k = 0;
    while (!acc && k < 300) begin
      step(1'b1, op, ad, dt, dly, n, dout,
           e, zx, zn, acc);
      k++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_wait cyc=%0d got=0 exp=1",
               cyc);
    end
    k = 0;
    while (cyc < rsp_cyc && k < 500) begin
      step(1'($urandom_range(0, 1)), 3'($urandom),
           17'($urandom), 8'($urandom), 0, 0,
           8'h00, 1'b0, 1'b0, 1'b0, junk);
      k++;
    end
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int k);
    bit junk;
    for (int i = 0; i < k; i++) begin
      step(1'b0, 3'd0, 17'd0, 8'd0, 0, 0,
           8'h00, 1'b0, 1'b0, 1'b0, junk);
    end
  endtask

  task automatic send_rand();
    int n;
    n = ($urandom_range(0, 5) == 0) ?
        0 : int'($urandom_range(1, 20));
    send(3'($urandom), 17'($urandom), 8'($urandom),
         int'($urandom_range(0, 8)), n, 8'($urandom),
         1'($urandom), 1'($urandom), 1'($urandom));
    idle(int'($urandom_range(0, 3)));
  endtask

  initial begin
    bit junk;
    for (int i = 0; i < NH; i++) begin
      fd_h[i] = 1'b1;
      er_h[i] = 1'b0;
      zx_h[i] = 1'b0;
      zn_h[i] = 1'b0;
      do_h[i] = 8'h00;
    end
    reset = 1'b1;
    req_valid = 1'b0;
    req_opcode = '0;
    req_addr = '0;
    req_data = '0;
    FLAG_DONE = 1'b1;
    FLAG_ERROR = 1'b0;
    FLAG_ZOOM_MAX = 1'b0;
    FLAG_ZOOM_MIN = 1'b0;
    DATA_OUT = 8'h00;
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b0;
    chk_en = 1'b1;

    send(LOAD, 17'h00123, 8'h11, 1, 10,
         8'hA5, 1'b0, 1'b0, 1'b0);
    chk("load_latency", dut_rsp_cyc - a_cyc, 17);
    chk("load_data", int'(rsp_data), 8'hA5);
    chk("load_timeout", int'(rsp_timeout), 0);
    chk("load_enable_low", en_low, 4);

    send(STORE, 17'h12BFF, 8'h3C, 0, 6,
         8'h77, 1'b0, 1'b0, 1'b0);
    chk("store_data", int'(rsp_data), 0);
    chk("store_addr", int'(MEM_ADDR), 17'h12BFF);

    send(ZOOM_IN_VP, 17'h00001, 8'h00, 2, 5,
         8'h00, 1'b0, 1'b1, 1'b0);
    chk("zoom_max", int'(rsp_zoom_max), 1);

    send(RESET_INST, 17'h00000, 8'h00, 0, 0,
         8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset_inst_latency", dut_rsp_cyc - a_cyc, 15);
    chk("reset_inst_timeout", int'(rsp_timeout), 0);

    send(ZOOM_OUT_MP, 17'h00002, 8'h00, 0, 0,
         8'h00, 1'b0, 1'b0, 1'b0);
    chk("busy_timeout_latency", dut_rsp_cyc - a_cyc, 71);
    chk("busy_timeout_flag", int'(rsp_timeout), 1);
    chk("busy_timeout_enable", int'(ENABLE), 1);

    send(ZOOM_IN_RP, 17'h00003, 8'h00, 0, 12,
         8'h00, 1'b1, 1'b0, 1'b1);
    chk("early_busy_latency", dut_rsp_cyc - a_cyc, 18);
    chk("early_busy_error", int'(rsp_error), 1);

    send(ZOOM_OUT_VD, 17'h00004, 8'h00, 0, 1,
         8'h00, 1'b0, 1'b0, 1'b0);
    chk("missed_busy_timeout", int'(rsp_timeout), 1);

    for (int i = 0; i < 50; i++) send_rand();

    junk = 1'b0;
    while (!junk) begin
      step(1'b1, LOAD, 17'h0ABCD, 8'h00, 1, 10,
           8'h5A, 1'b1, 1'b1, 1'b1, junk);
    end
    idle(4);
    #2;
    chk("strobe_before_reset", int'(ENABLE), 0);
    reset = 1'b1;
    #1;
    chk("reset_enable", int'(ENABLE), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk_en = 1'b0;
    a_cyc = -1000;
    rsp_cyc = -1000;
    win_n = 0;
    upd_cyc = -1000;
    c_op = '0; p_op = '0;
    c_ad = '0; p_ad = '0;
    c_dt = '0; p_dt = '0;
    c_to = 1'b0;
    e_data = '0;
    e_err = 1'b0; e_zx = 1'b0;
    e_zn = 1'b0; e_to = 1'b0;
    FLAG_ERROR = 1'b0;
    FLAG_ZOOM_MAX = 1'b0;
    FLAG_ZOOM_MIN = 1'b0;
    idle(3);
    #3;
    reset = 1'b0;
    chk_en = 1'b1;
    #3;
    chk("ready_after_reset", int'(req_ready), 1);
    chk("rsp_after_reset", int'(rsp_valid), 0);

    for (int i = 0; i < 5; i++) send_rand();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
